// File: rtl/seq_pkg.sv
// Shared types and constants for the branch sequencer: widths, state encoding,
// opcode map and status flag positions.
package seq_pkg;

   localparam int unsigned PC_W   = 8;
   localparam int unsigned OP_W   = 7;
   localparam int unsigned IW     = OP_W + PC_W;
   localparam int unsigned FLAG_W = 4;

   // Bit positions inside dataRegS
   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   typedef enum logic [1:0] {
      FETCH  = ST_FETCH,
      DECODE = ST_DECODE,
      EXEC   = ST_EXEC,
      HALTED = ST_HALTED
   } seqState_t;

   localparam logic [OP_W-1:0] OP_JMP  = 7'h60;
   localparam logic [OP_W-1:0] OP_JEQ  = 7'h61;
   localparam logic [OP_W-1:0] OP_JNE  = 7'h62;
   localparam logic [OP_W-1:0] OP_JGT  = 7'h63;
   localparam logic [OP_W-1:0] OP_JGE  = 7'h64;
   localparam logic [OP_W-1:0] OP_JLT  = 7'h65;
   localparam logic [OP_W-1:0] OP_JLE  = 7'h66;
   localparam logic [OP_W-1:0] OP_JCR  = 7'h67;
   localparam logic [OP_W-1:0] OP_JOV  = 7'h68;
   localparam logic [OP_W-1:0] OP_HALT = 7'h7F;

   // Instruction word layout: opcode in the upper bits, literal below
   typedef struct packed {
      logic [OP_W-1:0] opcode;
      logic [PC_W-1:0] literal;
   } instr_t;

endpackage

// File: rtl/branch_sequencer_jump_cond.sv
// Jump decoder: flags whether an opcode is a conditional/unconditional jump and
// whether its condition holds for the current status flags.
module jump_cond
   import seq_pkg::*;
(
   input  logic [OP_W-1:0]   opcode,
   input  logic [FLAG_W-1:0] dataRegS,
   output logic              isJump_c,
   output logic              condTrue_c
);

   logic flagZ;
   logic flagN;
   logic flagC;
   logic flagV;

   assign flagZ = dataRegS[FLAG_Z];
   assign flagN = dataRegS[FLAG_N];
   assign flagC = dataRegS[FLAG_C];
   assign flagV = dataRegS[FLAG_V];

   always_comb begin
      isJump_c   = 1'b1;
      condTrue_c = 1'b0;
      unique case (opcode)
         OP_JMP:  condTrue_c = 1'b1;
         OP_JEQ:  condTrue_c = flagZ;
         OP_JNE:  condTrue_c = ~flagZ;
         OP_JGT:  condTrue_c = ~flagZ & ~flagN;
         OP_JGE:  condTrue_c = ~flagN;
         OP_JLT:  condTrue_c = flagN;
         OP_JLE:  condTrue_c = flagN | flagZ;
         OP_JCR:  condTrue_c = flagC;
         OP_JOV:  condTrue_c = flagV;
         default: isJump_c   = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_sequencer.sv
// Three-cycle fetch/decode/execute sequencer owning PC and IR; resolves jumps
// from the status flags and stops permanently on HALT until reset.
module branch_sequencer
   import seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [IW-1:0]     im_data,
   input  logic [FLAG_W-1:0] dataRegS,
   output logic [PC_W-1:0]   im_addr,
   output logic [PC_W-1:0]   pc,
   output logic [OP_W-1:0]   opcode,
   output logic [PC_W-1:0]   literal,
   output logic              exec,
   output logic              jump_taken,
   output logic              halted
);

   seqState_t       state;
   seqState_t       stateNext;
   logic [PC_W-1:0] pcReg;
   logic [PC_W-1:0] pcNext;
   instr_t          ir;
   instr_t          irNext;
   logic            isJump;
   logic            condTrue;
   logic            isHalt;
   logic            execC;
   logic            jumpTakenC;

   jump_cond uJumpCond (
      .opcode     (ir.opcode),
      .dataRegS   (dataRegS),
      .isJump_c   (isJump),
      .condTrue_c (condTrue)
   );

   assign isHalt = (ir.opcode == OP_HALT);

   // State, PC and IR registers; reset overrides everything, including HALTED
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         pcReg <= '0;
         ir    <= '0;
      end else begin
         state <= stateNext;
         pcReg <= pcNext;
         ir    <= irNext;
      end
   end

   // Next-state and strobe decode; strobes only ever come from the EXEC state
   always_comb begin
      stateNext  = state;
      pcNext     = pcReg;
      irNext     = ir;
      execC      = 1'b0;
      jumpTakenC = 1'b0;
      unique case (state)
         FETCH: begin
            if (run) stateNext = DECODE;
         end
         DECODE: begin
            irNext    = instr_t'(im_data);
            stateNext = EXEC;
         end
         EXEC: begin
            stateNext = FETCH;
            if (isHalt) begin
               stateNext = HALTED;
            end else if (isJump) begin
               if (condTrue) begin
                  pcNext     = ir.literal;
                  jumpTakenC = 1'b1;
               end else begin
                  pcNext = pcReg + PC_W'(1);
               end
            end else begin
               execC  = 1'b1;
               pcNext = pcReg + PC_W'(1);
            end
         end
         HALTED: begin
            stateNext = HALTED;
         end
         default: stateNext = FETCH;
      endcase
   end

   assign im_addr    = pcReg;
   assign pc         = pcReg;
   assign opcode     = ir.opcode;
   assign literal    = ir.literal;
   assign exec       = execC;
   assign jump_taken = jumpTakenC;
   assign halted     = (state == HALTED);

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle instruction sequencer that sits in front of control_unit.
- Owns the PC and the instruction register.
- Fetches from the synchronous instruction ROM and feeds the 7-bit opcode to control_unit's address input.
- Emits a one-cycle execute strobe that gates datapath register and memory writes, and resolves conditional jumps from the status flags (dataRegS).

Parameters:
PC_W, 8, PC / ROM address width and jump-target literal width
OP_W, 7, opcode width (matches control_unit address)
IW, 15, instruction width = OP_W + PC_W, opcode in [14:8], literal in [7:0]

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
run  in  1  enable; 0 = hold at next FETCH boundary
im_data  in  IW  ROM read data, valid one cycle after im_addr
dataRegS  in  4  status flags: [0]=Z, [1]=N, [2]=C, [3]=V
im_addr  out  PC_W  ROM address, driven = pc
pc  out  PC_W  current program counter
opcode  out  OP_W  IR opcode, to control_unit address
literal  out  PC_W  IR literal, to datapath literal mux and jump target
exec  out  1  one-cycle strobe; datapath loads (lRegA, lRegB, wDM) ANDed with it
jump_taken  out  1  one-cycle pulse in EXEC when a jump resolves taken
halted  out  1  high while in HALTED

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=FETCH, pc=0, IR=0 (opcode=0, literal=0), exec=0, jump_taken=0, halted=0. rst wins over every other input, including mid-instruction and in HALTED.
- State register, 2 bits: FETCH, DECODE, EXEC, HALTED.
- FETCH: im_addr=pc. If run=1, go to DECODE; otherwise stay in FETCH with pc held.
- DECODE: IR <= im_data (1-cycle ROM latency), then go to EXEC. run is ignored once an instruction has started.
- EXEC: exactly one cycle, then FETCH (or HALTED).
  - Normal ALU/move opcode (not a jump, not HALT): exec=1, pc <= pc+1, modulo 2^PC_W (255 -> 0).
  - Jump opcode: exec=0. If the condition holds, pc <= literal and jump_taken=1; otherwise pc <= pc+1.
  - HALT opcode: exec=0, pc unchanged (points at the HALT), next state HALTED.
- Flags are sampled combinationally during the jump's EXEC cycle. They reflect the status register written by the previous instruction's EXEC. No forwarding is needed, since EXECs are never back to back.
- Jump conditions:
  - JMP: always
  - JEQ: Z
  - JNE: !Z
  - JGT: !Z & !N
  - JGE: !N
  - JLT: N
  - JLE: N|Z
  - JCR: C
  - JOV: V
- Jump to self (literal == pc) is legal and loops indefinitely.
- HALTED: halted=1, exec=0, all registers frozen. Exit only via rst.
- Throughput is 3 cycles per instruction with run=1. opcode and literal hold the last IR value between EXECs; only exec qualifies their use.
- Unknown opcodes outside the jump/HALT set go to control_unit unchanged. Its default case makes the datapath do nothing; the sequencer still pulses exec and increments pc.
- exec and jump_taken are registered-state decodes (state==EXEC), so they are glitch-free and never asserted together.

Decomposition:
- Package seq_pkg holds:
  - state encoding localparams
  - opcode constants: JMP=7'h60, JEQ=7'h61, JNE=7'h62, JGT=7'h63, JGE=7'h64, JLT=7'h65, JLE=7'h66, JCR=7'h67, JOV=7'h68, HALT=7'h7F
  - flag bit indices Z/N/C/V
- One sub-module, jump_cond: combinational (opcode, dataRegS) -> {is_jump, cond_true}. It can be verified exhaustively on its own.

Test Plan:
- Reset then run=1, ROM[0..2] = ALU ops (opcode 7'h00): exec pulses at cycles 3, 6, 9 after reset release; pc goes 0->1->2->3.
- ROM[5] = JEQ 0x20 with Z=1 -> pc=0x20 and jump_taken=1 for one cycle. The same instruction with Z=0 -> pc=6 and jump_taken=0.
- Sweep all 9 jump opcodes against all 16 dataRegS values -> taken or not taken exactly per the condition list. exec stays 0 on every jump.
- pc=0xFF holding a non-jump op -> pc wraps to 0x00. JMP 0xFF from pc=0x10 -> pc=0xFF.
- run dropped during DECODE -> the instruction completes (exec=1, pc increments), then the block stalls in FETCH with im_addr stable until run=1.
- HALT at pc=0x07 -> halted=1 and pc stays 0x07 for 20 cycles regardless of run. Then rst=1 for one cycle -> pc=0, halted=0, state FETCH. rst asserted during EXEC -> no pc update and exec=0 the next cycle.
